// File: rtl/arm_mem_pkg.sv
// Shared definitions for the EXE/MEM to off-chip SRAM access path.
package arm_mem_pkg;

    // Access sequencer states: one 16-bit half per LOW/HIGH phase
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // Byte address that maps onto SRAM word 0
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Halfword select appended below the word index to form sram_addr
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half-access. Synchronous clear has
// priority over counting; tc flags the last cycle of a half-access.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5,
    parameter int CW          = $clog2(WAIT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    // Count while enabled, return to zero on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_ctrl.sv
// Two-phase 32-bit access sequencer for a 16-bit asynchronous SRAM.
// Holds freeze while an access is in flight and pulses ready when done.
// Optional misalignment detection is compiled in with SRAM_ALIGN_CHECK_EN.
// Handshake: a request (mem_r_en | mem_w_en) seen in IDLE is accepted at
// that clock edge; freeze stays high until the DONE cycle, in which ready
// pulses for one cycle and the pipeline advances on the following edge.
module sram_access_ctrl
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 5,
    parameter int          SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_wdata,
    input  logic [15:0]            sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   err
);

    mem_state_e             state, state_n;
    logic                   req;
    logic                   busy;
    logic                   tc;
    logic                   start_access;
    logic                   is_wr_q;
    logic [15:0]            wdata_hi_q;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [SRAM_ADDR_W-2:0] word_n;
    logic [31:0]            offset;
    logic                   unused_bits;

    assign req    = mem_r_en | mem_w_en;
    assign busy   = (state == LOW) || (state == HIGH);
    assign offset = addr - BASE_ADDR;
    assign word_n = offset[SRAM_ADDR_W:2];
    assign unused_bits = &{1'b0, offset[31:SRAM_ADDR_W+1], offset[1:0]};

`ifdef SRAM_ALIGN_CHECK_EN
    logic misalign;
    logic err_q;

    assign misalign     = |addr[1:0];
    assign start_access = (state == IDLE) && req && !misalign;

    // Sticky misalignment flag, visible from the DONE cycle onwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && req && misalign) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign start_access = (state == IDLE) && req;
    assign err          = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!busy || tc),
        .en    (busy),
        .tc    (tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: LOW and HIGH each last WAIT_CYCLES, DONE lasts one cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_access) begin
                    state_n = LOW;
                end else if (req) begin
                    state_n = DONE;  // only reachable with a misaligned request
                end
            end
            LOW:     if (tc) state_n = HIGH;
            HIGH:    if (tc) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Latch the command, steer address/data per half, capture read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q    <= 1'b0;
            wdata_hi_q <= '0;
            word_q     <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata      <= '0;
        end else begin
            if (start_access) begin
                is_wr_q    <= mem_w_en;
                wdata_hi_q <= wdata[31:16];
                word_q     <= word_n;
                sram_addr  <= {word_n, HALF_LO};
                sram_wdata <= wdata[15:0];
            end
            if ((state == LOW) && tc) begin
                sram_addr  <= {word_q, HALF_HI};
                sram_wdata <= wdata_hi_q;
            end
            if (!is_wr_q && tc && (state == LOW)) begin
                rdata[15:0] <= sram_rdata;
            end
            if (!is_wr_q && tc && (state == HIGH)) begin
                rdata[31:16] <= sram_rdata;
            end
        end
    end

    // Strobes: write pulse releases on the last cycle so address/data hold
    assign sram_we_n = !(busy && is_wr_q && !tc);
    assign sram_oe_n = !(busy && !is_wr_q);
    assign freeze    = ((state == IDLE) && req) || busy;
    assign ready     = (state == DONE);

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a 64-halfword SRAM model.
module tb_sram_access_ctrl;

    localparam int WAIT = 5;

    logic        clk;
    logic        rst_n;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        err;

    logic [15:0] mem [64];
    int          we_cnt;
    int          oe_cnt;
    int          checks;
    int          failures;

    sram_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .err        (err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: asynchronous read, write sampled while we_n is low
    assign sram_rdata = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            we_cnt = we_cnt + 1;
            mem[sram_addr[5:0]] = sram_wdata;
        end
        if (!sram_oe_n) begin
            oe_cnt = oe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access starting in an IDLE cycle; returns at the ready cycle
    task automatic run_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic hold, output int rdy_cyc, output int frz,
                              output logic [17:0] lo_a, output logic [17:0] hi_a);
        mem_w_en = wr;
        mem_r_en = !wr;
        addr     = a;
        wdata    = d;
        rdy_cyc  = -1;
        frz      = 0;
        lo_a     = '1;
        hi_a     = '1;
        #1;
        for (int k = 1; k <= 40; k++) begin
            if (freeze) frz++;
            if (k == 2) lo_a = sram_addr;
            if (k == 2 + WAIT) hi_a = sram_addr;
            if (ready) begin
                rdy_cyc = k;
                break;
            end
            step();
            if (!hold) begin
                mem_w_en = 1'b0;
                mem_r_en = 1'b0;
            end
        end
    endtask

    initial begin
        int          rdy;
        int          frz;
        int          cnt_a;
        int          cnt_b;
        logic [17:0] lo;
        logic [17:0] hi;

        checks   = 0;
        failures = 0;
        we_cnt   = 0;
        oe_cnt   = 0;
        rst_n    = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        addr     = '0;
        wdata    = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;
        mem[4] = 16'hA5A5;
        mem[5] = 16'h5A5A;

        // Reset values
        step(); step(); step();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(); step();
        check("idle_freeze", 32'(freeze), 32'd0);
        check("idle_ready", 32'(ready), 32'd0);

        // Write 0xDEADBEEF to 1024
        we_cnt = 0; oe_cnt = 0;
        run_access(1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, rdy, frz, lo, hi);
        check("wr_ready_cycle", 32'(rdy), 32'd12);
        check("wr_freeze_cycles", 32'(frz), 32'd11);
        check("wr_we_low_cycles", 32'(we_cnt), 32'd8);
        check("wr_oe_low_cycles", 32'(oe_cnt), 32'd0);
        check("wr_lo_addr", 32'(lo), 32'd0);
        check("wr_hi_addr", 32'(hi), 32'd1);
        check("wr_mem0", 32'(mem[0]), 32'h0000BEEF);
        check("wr_mem1", 32'(mem[1]), 32'h0000DEAD);
        check("wr_rdata_untouched", rdata, 32'd0);
        step();
        check("wr_after_freeze", 32'(freeze), 32'd0);

        // Read it back
        we_cnt = 0; oe_cnt = 0;
        run_access(1'b0, 32'd1024, 32'h0, 1'b0, rdy, frz, lo, hi);
        check("rd_ready_cycle", 32'(rdy), 32'd12);
        check("rd_freeze_cycles", 32'(frz), 32'd11);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_oe_low_cycles", 32'(oe_cnt), 32'd10);
        check("rd_we_low_cycles", 32'(we_cnt), 32'd0);
        check("rd_lo_addr", 32'(lo), 32'd0);
        check("rd_hi_addr", 32'(hi), 32'd1);
        step();

        // Back-to-back reads with request held
        run_access(1'b0, 32'd1028, 32'h0, 1'b1, rdy, frz, lo, hi);
        check("b2b_a_ready_cycle", 32'(rdy), 32'd12);
        check("b2b_a_freeze_cycles", 32'(frz), 32'd11);
        check("b2b_a_lo_addr", 32'(lo), 32'd2);
        check("b2b_a_hi_addr", 32'(hi), 32'd3);
        check("b2b_a_rdata", rdata, 32'h44443333);
        check("b2b_done_freeze", 32'(freeze), 32'd0);
        step();
        run_access(1'b0, 32'd1032, 32'h0, 1'b1, rdy, frz, lo, hi);
        check("b2b_b_ready_cycle", 32'(rdy), 32'd12);
        check("b2b_b_freeze_cycles", 32'(frz), 32'd11);
        check("b2b_b_lo_addr", 32'(lo), 32'd4);
        check("b2b_b_hi_addr", 32'(hi), 32'd5);
        check("b2b_b_rdata", rdata, 32'h5A5AA5A5);
        mem_r_en = 1'b0;
        step();
        check("b2b_idle_freeze", 32'(freeze), 32'd0);
        check("b2b_idle_addr_hold", 32'(sram_addr), 32'd5);
        check("b2b_idle_oe_n", 32'(sram_oe_n), 32'd1);

        // Write elsewhere: rdata must hold
        run_access(1'b1, 32'd1048, 32'hCAFEF00D, 1'b0, rdy, frz, lo, hi);
        check("wr2_ready_cycle", 32'(rdy), 32'd12);
        check("wr2_lo_addr", 32'(lo), 32'd12);
        check("wr2_hi_addr", 32'(hi), 32'd13);
        check("wr2_mem12", 32'(mem[12]), 32'h0000F00D);
        check("wr2_mem13", 32'(mem[13]), 32'h0000CAFE);
        check("wr2_rdata_hold", rdata, 32'h5A5AA5A5);
        check("wr2_err", 32'(err), 32'd0);
        step();

        // Reset during HIGH of a write
        mem_w_en = 1'b1;
        addr     = 32'd1040;
        wdata    = 32'h12345678;
        #1;
        for (int k = 0; k < 7; k++) begin
            step();
            mem_w_en = 1'b0;
        end
        check("mid_high_addr", 32'(sram_addr), 32'd9);
        check("mid_high_we_n", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_we_n", 32'(sram_we_n), 32'd1);
        check("async_oe_n", 32'(sram_oe_n), 32'd1);
        check("async_freeze", 32'(freeze), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_sram_addr", 32'(sram_addr), 32'd0);
        check("async_sram_wdata", 32'(sram_wdata), 32'd0);
        check("async_rdata", rdata, 32'd0);
        step(); step();
        rst_n  = 1'b1;
        we_cnt = 0;
        cnt_a  = 0;
        cnt_b  = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (freeze) cnt_a++;
            if (ready) cnt_b++;
        end
        check("post_rst_we_pulses", 32'(we_cnt), 32'd0);
        check("post_rst_freeze_cycles", 32'(cnt_a), 32'd0);
        check("post_rst_ready_pulses", 32'(cnt_b), 32'd0);

`ifdef SRAM_ALIGN_CHECK_EN
        // Misaligned read completes without touching the SRAM
        oe_cnt = 0;
        run_access(1'b0, 32'd1026, 32'h0, 1'b0, rdy, frz, lo, hi);
        check("align_ready_cycle", 32'(rdy), 32'd2);
        check("align_freeze_cycles", 32'(frz), 32'd1);
        check("align_err_done", 32'(err), 32'd1);
        check("align_rdata_hold", rdata, 32'd0);
        step(); step(); step();
        check("align_oe_low_cycles", 32'(oe_cnt), 32'd0);
        check("align_err_sticky", 32'(err), 32'd1);
`else
        // Misaligned address is simply truncated: 1026 reads word 0
        run_access(1'b0, 32'd1026, 32'h0, 1'b0, rdy, frz, lo, hi);
        check("noalign_ready_cycle", 32'(rdy), 32'd12);
        check("noalign_rdata", rdata, 32'hDEADBEEF);
        check("noalign_err", 32'(err), 32'd0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
